// File: rtl/osc_pkg.sv
// Shared constants and types for the oscilloscope trigger/capture stage.
package osc_pkg;

  localparam int OSC_DW    = 12;
  localparam int OSC_DEPTH = 800;
  localparam int OSC_AW    = 10;

  localparam logic OSC_SLOPE_RISE = 1'b0;
  localparam logic OSC_SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } osc_state_t;

endpackage

// File: rtl/osc_trigger_capture_if.sv
// Sample-stream, control and frame-read bundle of osc_trigger_capture.
interface osc_trigger_capture_if #(
  parameter int DW = 12,
  parameter int AW = 10
);
  // smp_valid is a one-cycle strobe with no back-pressure; arm and frame_ack are
  // one-cycle pulses; frame_ready stays high until the cycle after frame_ack, and
  // rd_data follows rd_addr one cycle later and is meaningful only while frame_ready.
  logic          smp_valid;
  logic [2:0]    smp_addr;
  logic [DW-1:0] smp_data;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic          arm;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          frame_ready;
  logic          triggered;
  logic          busy;
  logic          auto_trig;

  modport master (
    output smp_valid, smp_addr, smp_data, trig_level, trig_slope, arm, frame_ack, rd_addr,
    input  rd_data, frame_ready, triggered, busy, auto_trig
  );

  modport slave (
    input  smp_valid, smp_addr, smp_data, trig_level, trig_slope, arm, frame_ack, rd_addr,
    output rd_data, frame_ready, triggered, busy, auto_trig
  );
endinterface

// File: rtl/osc_sample_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module osc_sample_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 800,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/osc_trigger_capture.sv
// Channel select, hysteresis level trigger and pre/post-trigger frame capture.
// Define OSC_AUTO_TRIG_EN to force a trigger after TIMEOUT samples in WAIT.
module osc_trigger_capture
  import osc_pkg::*;
#(
  parameter int DW    = OSC_DW,
  parameter int DEPTH = OSC_DEPTH,
  parameter int AW    = OSC_AW,
  parameter int PRE   = 100,
  parameter int CH    = 0,
  parameter int HYST  = 16
`ifdef OSC_AUTO_TRIG_EN
  , parameter int TIMEOUT = 2**20
`endif
) (
  input  logic clk,
  input  logic rst,
  osc_trigger_capture_if.slave bus,
  output osc_state_t state_o
);
  localparam int POST_N = DEPTH - PRE - 1;
  localparam logic POST_NONE = (POST_N == 0);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_N == 0) ? 0 : POST_N - 1);

  osc_state_t    state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, start_ptr_q, start_calc, rd_phys;
  logic [DW-1:0] level_q, thr_lo, thr_hi, ram_rdata;
  logic [DW:0]   lo_ext, hi_ext;
  logic [AW:0]   rd_sum;
  logic          slope_q, hyst_q, triggered_q, frame_ready_q, oob_q;
  logic          accept, capturing, restart, we, rd_oob, arm_cond, hit, real_fire, fire;

  assign accept    = bus.smp_valid && (bus.smp_addr == 3'(CH));
  assign capturing = (state_q == osc_pkg::PRE) || (state_q == osc_pkg::WAIT) ||
                     (state_q == osc_pkg::POST);
  // A held frame only restarts when the consumer releases it in the same cycle.
  assign restart   = bus.arm && ((state_q != osc_pkg::DONE) || bus.frame_ack);
  assign we        = accept && capturing && !bus.arm;
  assign wr_ptr_d  = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;

  assign lo_ext = {1'b0, level_q} - (DW+1)'(HYST);
  assign hi_ext = {1'b0, level_q} + (DW+1)'(HYST);
  assign thr_lo = lo_ext[DW] ? '0 : lo_ext[DW-1:0];
  assign thr_hi = hi_ext[DW] ? '1 : hi_ext[DW-1:0];

  assign arm_cond  = (slope_q == OSC_SLOPE_FALL) ? (bus.smp_data > thr_hi) : (bus.smp_data < thr_lo);
  assign hit       = (slope_q == OSC_SLOPE_FALL) ? (bus.smp_data <= level_q) : (bus.smp_data >= level_q);
  assign real_fire = accept && (state_q == osc_pkg::WAIT) && hyst_q && hit;
  assign start_calc = (wr_ptr_q >= AW'(PRE)) ? wr_ptr_q - AW'(PRE) : wr_ptr_q + AW'(DEPTH - PRE);

`ifdef OSC_AUTO_TRIG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q;
  logic            auto_q, to_hit;
  assign to_hit = accept && (state_q == osc_pkg::WAIT) && (to_q == TO_W'(TIMEOUT - 1));
  assign fire   = real_fire || to_hit;
  assign bus.auto_trig = auto_q;
`else
  assign fire   = real_fire;
  assign bus.auto_trig = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= osc_pkg::IDLE;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      start_ptr_q   <= '0;
      level_q       <= '0;
      slope_q       <= 1'b0;
      hyst_q        <= 1'b0;
      triggered_q   <= 1'b0;
      frame_ready_q <= 1'b0;
`ifdef OSC_AUTO_TRIG_EN
      to_q          <= '0;
      auto_q        <= 1'b0;
`endif
    end else begin
      if (we) wr_ptr_q <= wr_ptr_d;
      if (restart) begin
        state_q       <= osc_pkg::PRE;
        cnt_q         <= '0;
        hyst_q        <= 1'b0;
        triggered_q   <= 1'b0;
        frame_ready_q <= 1'b0;
        level_q       <= bus.trig_level;
        slope_q       <= bus.trig_slope;
`ifdef OSC_AUTO_TRIG_EN
        to_q          <= '0;
        auto_q        <= 1'b0;
`endif
      end else begin
        case (state_q)
          osc_pkg::PRE: if (accept) begin
            if (cnt_q == PRE_LAST) begin
              state_q <= osc_pkg::WAIT;
              cnt_q   <= '0;
              hyst_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          osc_pkg::WAIT: if (accept) begin
            if (fire) begin
              state_q       <= POST_NONE ? osc_pkg::DONE : osc_pkg::POST;
              frame_ready_q <= POST_NONE;
              triggered_q   <= 1'b1;
              start_ptr_q   <= start_calc;
              cnt_q         <= '0;
`ifdef OSC_AUTO_TRIG_EN
              auto_q        <= !real_fire;
`endif
            end else if (arm_cond) begin
              hyst_q <= 1'b1;
            end
`ifdef OSC_AUTO_TRIG_EN
            to_q <= to_q + 1'b1;
`endif
          end
          osc_pkg::POST: if (accept) begin
            if (cnt_q == POST_LAST) begin
              state_q       <= osc_pkg::DONE;
              frame_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          osc_pkg::DONE: if (bus.frame_ack) begin
            state_q       <= osc_pkg::IDLE;
            frame_ready_q <= 1'b0;
            triggered_q   <= 1'b0;
`ifdef OSC_AUTO_TRIG_EN
            auto_q        <= 1'b0;
`endif
          end
          default: state_q <= osc_pkg::IDLE;
        endcase
      end
    end
  end

  // Logical frame index to physical RAM address; out-of-range reads return zero.
  assign rd_sum  = {1'b0, start_ptr_q} + {1'b0, bus.rd_addr};
  assign rd_oob  = {1'b0, bus.rd_addr} >= (AW+1)'(DEPTH);
  assign rd_phys = rd_oob ? '0 :
                   (rd_sum >= (AW+1)'(DEPTH)) ? AW'(rd_sum - (AW+1)'(DEPTH)) : AW'(rd_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oob_q <= 1'b0;
    else     oob_q <= rd_oob;
  end

  osc_sample_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.smp_data),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign bus.rd_data     = oob_q ? '0 : ram_rdata;
  assign bus.frame_ready = frame_ready_q;
  assign bus.triggered   = triggered_q;
  assign bus.busy        = capturing;
  assign state_o         = state_q;
endmodule
